// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU slice: the 4-bit operation codes used by the
// ALU, the decoder and the benches, the datapath width, and a small helper
// that tells the multiplier how to extend each operand.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_SEL_W  = 4;
   localparam int ALU_SHAMT_W = 5;

   // Operation select codes. Code 15 is deliberately left undefined and
   // produces a zero result.
   typedef enum logic [ALU_SEL_W-1:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_AND    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_SLL    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_SLT    = 4'd8,
      ALU_SLTU   = 4'd9,
      ALU_MUL    = 4'd10,
      ALU_MULH   = 4'd11,
      ALU_MULHSU = 4'd12,
      ALU_MULHU  = 4'd13,
      ALU_PASSB  = 4'd14,
      ALU_UNDEF  = 4'd15
   } alu_op_e;

   // How each multiplier operand is widened before the 33x33 product.
   typedef struct packed {
      logic a_signed;
      logic b_signed;
   } mul_mode_t;

   // MULH treats both operands as signed, MULHSU only A, MULHU neither.
   // The low product word is identical for every mode, so MUL can use any.
   function automatic mul_mode_t mul_mode_for(input alu_op_e op);
      mul_mode_t mode;
      mode.a_signed = 1'b0;
      mode.b_signed = 1'b0;
      case (op)
         ALU_MUL,
         ALU_MULH: begin
            mode.a_signed = 1'b1;
            mode.b_signed = 1'b1;
         end
         ALU_MULHSU: begin
            mode.a_signed = 1'b1;
         end
         default: begin
            mode.a_signed = 1'b0;
            mode.b_signed = 1'b0;
         end
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if
// Bundles the ALU operand/select inputs and the registered result/flags.
//   bus_a, bus_b : operands (two's complement), bus_b[4:0] is the shift amount
//   alu_sel      : operation select (alu_op_e codes)
//   alu_out      : registered result
//   alu_zero     : registered flag, alu_out == 0
//   alu_neg      : registered flag, alu_out sign bit
// master drives operands and select, slave is the ALU itself.
// ---------------------------------------------------------------------------
interface alu_if
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
);

   logic [DATA_W-1:0]    bus_a;
   logic [DATA_W-1:0]    bus_b;
   logic [ALU_SEL_W-1:0] alu_sel;
   logic [DATA_W-1:0]    alu_out;
   logic                 alu_zero;
   logic                 alu_neg;

   modport master (
      output bus_a,
      output bus_b,
      output alu_sel,
      input  alu_out,
      input  alu_zero,
      input  alu_neg
   );

   modport slave (
      input  bus_a,
      input  bus_b,
      input  alu_sel,
      output alu_out,
      output alu_zero,
      output alu_neg
   );

endinterface

// File: rtl/alu_mul.sv
// ---------------------------------------------------------------------------
// alu_mul
// Purely combinational multiplier. Each operand is widened by one bit, either
// sign- or zero-extended, and the two 33-bit signed values are multiplied.
// The full product of any signed/unsigned mix of 32-bit operands fits in a
// signed 64-bit value, so the low 64 bits are the exact product.
//   a, b     : 32-bit operands
//   a_signed : extend a with its sign bit (else zero)
//   b_signed : extend b with its sign bit (else zero)
//   prod     : 64-bit product
// ---------------------------------------------------------------------------
module alu_mul
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic                a_signed,
   input  logic                b_signed,
   output logic [2*DATA_W-1:0] prod
);

   logic signed [DATA_W:0]     a_ext;
   logic signed [DATA_W:0]     b_ext;
   logic signed [2*DATA_W-1:0] prod_s;

   // The extra top bit decides whether the operand is read as signed or
   // unsigned by the signed multiplier below.
   assign a_ext = {a_signed & a[DATA_W-1], a};
   assign b_ext = {b_signed & b[DATA_W-1], b};

   // Both operands are sign-extended to the 64-bit assignment width before
   // multiplying, which keeps the low 64 bits of the true product.
   assign prod_s = a_ext * b_ext;
   assign prod   = prod_s;

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Single-cycle ALU with one output register stage. The result is formed
// combinationally from bus_a, bus_b and alu_sel and captured on every rising
// clk edge together with its zero and negative flags.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (out=0, zero=1, neg=0)
//   bus : alu_if slave (operands, select in; result and flags out)
// ---------------------------------------------------------------------------
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input logic  clk,
   input logic  rst,
   alu_if.slave bus
);

   alu_op_e             op;
   mul_mode_t           mode;
   logic [2*DATA_W-1:0] prod;
   logic [ALU_SHAMT_W-1:0] shamt;
   logic [DATA_W-1:0]   result;
   logic                signed_lt;
   logic                unsigned_lt;

   assign op    = alu_op_e'(bus.alu_sel);
   assign shamt = bus.bus_b[ALU_SHAMT_W-1:0];
   assign mode  = mul_mode_for(op);

   assign signed_lt   = $signed(bus.bus_a) < $signed(bus.bus_b);
   assign unsigned_lt = bus.bus_a < bus.bus_b;

   alu_mul #(
      .DATA_W   (DATA_W)
   ) u_mul (
      .a        (bus.bus_a),
      .b        (bus.bus_b),
      .a_signed (mode.a_signed),
      .b_signed (mode.b_signed),
      .prod     (prod)
   );

   // Result selection. Add/sub wrap naturally at DATA_W bits; shifts only
   // look at the low five bits of b; the undefined code falls to zero.
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:    result = bus.bus_a + bus.bus_b;
         ALU_SUB:    result = bus.bus_a - bus.bus_b;
         ALU_AND:    result = bus.bus_a & bus.bus_b;
         ALU_OR:     result = bus.bus_a | bus.bus_b;
         ALU_XOR:    result = bus.bus_a ^ bus.bus_b;
         ALU_SLL:    result = bus.bus_a << shamt;
         ALU_SRL:    result = bus.bus_a >> shamt;
         ALU_SRA:    result = $signed(bus.bus_a) >>> shamt;
         ALU_SLT:    result = {{(DATA_W-1){1'b0}}, signed_lt};
         ALU_SLTU:   result = {{(DATA_W-1){1'b0}}, unsigned_lt};
         ALU_MUL:    result = prod[DATA_W-1:0];
         ALU_MULH,
         ALU_MULHSU,
         ALU_MULHU:  result = prod[2*DATA_W-1:DATA_W];
         ALU_PASSB:  result = bus.bus_b;
         default:    result = '0;
      endcase
   end

   // Output register. The flags are computed from the same result word that
   // is captured, so out/zero/neg always describe one operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.alu_out  <= '0;
         bus.alu_zero <= 1'b1;
         bus.alu_neg  <= 1'b0;
      end else begin
         bus.alu_out  <= result;
         bus.alu_zero <= (result == '0);
         bus.alu_neg  <= result[DATA_W-1];
      end
   end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Directed-vector bench for alu. Each vector drives operands and select, waits
// one rising edge and compares the registered result and both flags against
// hand-computed values. Also exercises asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_alu;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   alu_if #(.DATA_W(32)) bus ();

   alu #(
      .DATA_W (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
      end
   endtask

   // Drive one operation away from the active edge, then let it be captured.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] sel);
      @(negedge clk);
      bus.bus_a   = a;
      bus.bus_b   = b;
      bus.alu_sel = sel;
      @(posedge clk);
      #1;
   endtask

   task automatic runVector(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] sel,
                            input logic [31:0] exp_out, input logic exp_zero,
                            input logic exp_neg);
      applyStimulus(a, b, sel);
      checkOutput({tag, " out"},  bus.alu_out, exp_out);
      checkOutput({tag, " zero"}, {31'b0, bus.alu_zero}, {31'b0, exp_zero});
      checkOutput({tag, " neg"},  {31'b0, bus.alu_neg},  {31'b0, exp_neg});
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " out"},  bus.alu_out, 32'h0000_0000);
      checkOutput({tag, " zero"}, {31'b0, bus.alu_zero}, 32'd1);
      checkOutput({tag, " neg"},  {31'b0, bus.alu_neg},  32'd0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      bus.bus_a    = 32'hDEAD_BEEF;
      bus.bus_b    = 32'h1234_5678;
      bus.alu_sel  = ALU_ADD;
      rst          = 1'b1;

      // Reset takes effect before any clock edge.
      #1;
      checkResetState("reset_initial");
      @(posedge clk);
      #1;
      checkResetState("reset_held_edge");
      @(negedge clk);
      rst = 1'b0;

      // Arithmetic and flags.
      runVector("add_5_3",     32'd5,         32'd3,         ALU_ADD,  32'h0000_0008, 1'b0, 1'b0);
      runVector("sub_5_8",     32'd5,         32'd8,         ALU_SUB,  32'hFFFF_FFFD, 1'b0, 1'b1);
      runVector("add_wrap",    32'hFFFF_FFFF, 32'd1,         ALU_ADD,  32'h0000_0000, 1'b1, 1'b0);
      runVector("add_ovf",     32'h7FFF_FFFF, 32'd1,         ALU_ADD,  32'h8000_0000, 1'b0, 1'b1);
      runVector("sub_wrap",    32'h8000_0000, 32'd1,         ALU_SUB,  32'h7FFF_FFFF, 1'b0, 1'b0);

      // Logic.
      runVector("and",         32'hFFFF_FFFF, 32'h0000_FFFF, ALU_AND,  32'h0000_FFFF, 1'b0, 1'b0);
      runVector("or",          32'hFFFF_FFFF, 32'h0000_FFFF, ALU_OR,   32'hFFFF_FFFF, 1'b0, 1'b1);
      runVector("xor",         32'hFFFF_FFFF, 32'h0000_FFFF, ALU_XOR,  32'hFFFF_0000, 1'b0, 1'b1);

      // Shifts, including shift-by-zero and ignored upper bits of b.
      runVector("sll_1_2",     32'd1,         32'd2,         ALU_SLL,  32'h0000_0004, 1'b0, 1'b0);
      runVector("srl_24",      32'h8000_0000, 32'h0000_0018, ALU_SRL,  32'h0000_0080, 1'b0, 1'b0);
      runVector("sra_24",      32'h8000_0000, 32'h0000_0018, ALU_SRA,  32'hFFFF_FF80, 1'b0, 1'b1);
      runVector("sll_by0",     32'hA5A5_0001, 32'h0000_0000, ALU_SLL,  32'hA5A5_0001, 1'b0, 1'b1);
      runVector("sll_hi_ign",  32'h0000_0003, 32'hFFFF_FFE1, ALU_SLL,  32'h0000_0006, 1'b0, 1'b0);
      runVector("sra_by0",     32'h8000_0001, 32'h0000_0020, ALU_SRA,  32'h8000_0001, 1'b0, 1'b1);
      runVector("srl_31",      32'hFFFF_FFFF, 32'd31,        ALU_SRL,  32'h0000_0001, 1'b0, 1'b0);

      // Compares.
      runVector("slt_m5_3",    32'hFFFF_FFFB, 32'd3,         ALU_SLT,  32'h0000_0001, 1'b0, 1'b0);
      runVector("sltu_m5_3",   32'hFFFF_FFFB, 32'd3,         ALU_SLTU, 32'h0000_0000, 1'b1, 1'b0);
      runVector("sltu_3_m5",   32'd3,         32'hFFFF_FFFB, ALU_SLTU, 32'h0000_0001, 1'b0, 1'b0);

      // Multiplies.
      runVector("mul_2_3",     32'd2,         32'd3,         ALU_MUL,    32'h0000_0006, 1'b0, 1'b0);
      runVector("mul_m1_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MUL,    32'h0000_0001, 1'b0, 1'b0);
      runVector("mulh_m1_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MULH,   32'h0000_0000, 1'b1, 1'b0);
      runVector("mulhu_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MULHU,  32'hFFFF_FFFE, 1'b0, 1'b1);
      runVector("mulhsu_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MULHSU, 32'hFFFF_FFFF, 1'b0, 1'b1);
      runVector("mulh_min_2",  32'h8000_0000, 32'd2,         ALU_MULH,   32'hFFFF_FFFF, 1'b0, 1'b1);
      runVector("mulhu_min_2", 32'h8000_0000, 32'd2,         ALU_MULHU,  32'h0000_0001, 1'b0, 1'b0);

      // Pass-through and undefined code.
      runVector("passb",       32'h1111_1111, 32'h8765_4321, ALU_PASSB, 32'h8765_4321, 1'b0, 1'b1);
      runVector("undef_15",    32'h1234_5678, 32'h0000_0001, 4'd15,     32'h0000_0000, 1'b1, 1'b0);

      // Reset between edges during an ADD stream.
      runVector("stream_add1", 32'd100,       32'd23,        ALU_ADD,  32'h0000_007B, 1'b0, 1'b0);
      runVector("stream_add2", 32'hFFFF_FF00, 32'd1,         ALU_ADD,  32'hFFFF_FF01, 1'b0, 1'b1);
      bus.bus_a = 32'd10;
      bus.bus_b = 32'd20;
      #1;
      rst = 1'b1;
      #1;
      checkResetState("reset_midstream");
      @(posedge clk);
      #1;
      checkResetState("reset_mid_edge");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_reset out",  bus.alu_out, 32'h0000_001E);
      checkOutput("post_reset zero", {31'b0, bus.alu_zero}, 32'd0);
      checkOutput("post_reset neg",  {31'b0, bus.alu_neg},  32'd0);

      runVector("undef_after", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0000_0000, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; only 32 is required to be supported.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset (see Reset).
REQ-005 bus_a  input  32  operand A, signed two's complement.
REQ-006 bus_b  input  32  operand B, signed two's complement; bits [4:0] are the shift amount for shifts.
REQ-007 alu_sel  input  4  operation select, using the shared ALU_* codes.
REQ-008 alu_out  output  32  registered signed result.
REQ-009 alu_zero  output  1  registered flag: 1 when alu_out is 0.
REQ-010 alu_neg  output  1  registered flag: equal to alu_out[31].

Function
REQ-011 The result SHALL be computed combinationally from bus_a, bus_b and alu_sel, then captured into alu_out on each rising clk edge (latency 1 cycle, one new operation per cycle, no handshake).
REQ-012 Codes: ADD=0 a+b; SUB=1 a-b; AND=2; OR=3; XOR=4; SLL=5 a<<b[4:0]; SRL=6 logical a>>b[4:0]; SRA=7 arithmetic a>>>b[4:0].
REQ-013 Codes, continued: SLT=8 signed a<b gives 1 else 0; SLTU=9 unsigned a<b gives 1 else 0; MUL=10 low 32 bits of a*b.
REQ-014 Codes, continued: MULH=11 high 32 bits of signed*signed; MULHSU=12 high 32 bits of signed a * unsigned b; MULHU=13 high 32 bits of unsigned*unsigned; PASSB=14 result = b.
REQ-015 Code 15 (undefined) SHALL produce result 0, so alu_zero=1.
REQ-016 ADD and SUB SHALL wrap modulo 2^32; no overflow or carry output.
REQ-017 Shifts SHALL use only b[4:0]; b[31:5] are ignored, and a shift by 0 returns a unchanged.
REQ-018 Products SHALL be formed as a 64-bit value, with the low or high word selected per REQ-013/014.
REQ-019 alu_zero and alu_neg SHALL be derived from the same result value registered into alu_out, so all three always refer to the same operation.
REQ-020 An alu_sel or operand change SHALL affect only the next edge's capture; there is no internal multi-cycle state.

Reset
REQ-021 While rst=1, alu_out SHALL be 0, alu_zero SHALL be 1 and alu_neg SHALL be 0, immediately and independent of clk.
REQ-022 On rst deassertion, the first rising clk edge SHALL register the current operation normally.
REQ-023 Reset asserted mid-stream SHALL discard the pending result; there is no other state.

Structure
REQ-024 The ALU_* operation codes (4-bit) SHALL live in one shared defines/package file, included by alu, the decoder and benches; no literal codes appear in alu.
REQ-025 The 33x33-bit signed multiply (sign extension per REQ-013/014) SHALL be a sub-module alu_mul, which is combinational and returns the 64-bit product.
REQ-026 Everything else SHALL be a single combinational case on alu_sel followed by one output register stage in alu.

Verification
REQ-027 a=5, b=3, ADD, one edge -> alu_out=00000008, zero=0, neg=0; a=5, b=8, SUB -> FFFFFFFD, zero=0, neg=1.
REQ-028 a=FFFFFFFF, b=0000FFFF: AND -> 0000FFFF, neg=0; OR -> FFFFFFFF, neg=1; XOR -> FFFF0000, neg=1.
REQ-029 a=1, b=2, SLL -> 00000004; a=80000000, b=24 (hex 0x18; b[4:0]=24): SRL -> 00000080, SRA -> FFFFFF80.
REQ-030 a=2, b=3, MUL -> 00000006; a=-1, b=-1, MULH -> 00000000, MULHU -> FFFFFFFE.
REQ-031 a=-5, b=3: SLT -> 00000001, SLTU -> 00000000, the latter with zero=1.
REQ-032 Assert rst between edges during an ADD stream -> outputs go to 0/1/0 without waiting for a clk edge; after release, the first edge gives the correct result; alu_sel=15 -> 0, zero=1.
